dpc_inbuf: RTL

Input sample buffer that sits directly upstream of the datapath controller (dpc) and the data memory in myfilter. It accepts samples from the external source over a valid/ready handshake and stores them in a small circular FIFO. It drives `extready_out` to the dpc whenever at least one sample is held. Each dmem SHIFT command issued by the dpc pops one sample into the delay line.

---
 rtl/dpc_inbuf.sv | 97 +++++++++
 1 files changed

// File: rtl/dpc_inbuf.sv
// Input sample buffer ahead of the dpc/dmem: a small circular FIFO.
// Samples enter on a valid/ready handshake, and each dmem SHIFT pops the head.
module dpc_inbuf #(
  parameter int DATABITS = 16,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ext_valid_in,
  input  logic [DATABITS-1:0]        ext_data_in,
  output logic                       ext_ready_out,
  input  logic                       shift_in,
  output logic [DATABITS-1:0]        sample_out,
  output logic                       extready_out,
  output logic [$clog2(DEPTH+1)-1:0] level_out,
  output logic                       underflow_out,
  input  logic                       clr_in
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                underflow_q, underflow_d;
  logic [DATABITS-1:0] mem_q [DEPTH];
  logic [DATABITS-1:0] mem_d [DEPTH];

  logic push, pop;

  // Outputs depend on registered state only, so no input-to-output path exists.
  assign ext_ready_out = (count_q != CNT_FULL);
  assign extready_out  = (count_q != '0);
  assign sample_out    = mem_q[rd_ptr_q];
  assign level_out     = count_q;
  assign underflow_out = underflow_q;

  assign push = ext_valid_in && ext_ready_out;
  assign pop  = shift_in && extready_out;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    mem_d       = mem_q;

    if (clr_in) begin
      // Flush only the bookkeeping; stale mem contents remain but are unreachable as valid data.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ext_data_in;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // A shift while empty is dropped but remembered, even if a push lands in the same cycle.
      if (shift_in && !extready_out) begin
        underflow_d = 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      // NOTE: the storage array is reset too, so sample_out is never X, even while empty.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      mem_q       <= mem_d;
    end
  end

endmodule
